// File: rtl/dsa_pkg.sv
// Shared definitions for the SIMD fetch unit: state encoding and default widths.
package dsa_pkg;

    localparam int DSA_SIMD_WIDTH = 4;
    localparam int DSA_FRAC_BITS  = 8;

    typedef enum logic [2:0] {
        IDLE,
        CALC,
        READ,
        DRAIN,
        DONE
    } fetch_state_t;

endpackage

// File: rtl/dsa_coord_mapper.sv
// Maps one output-image coordinate to its two clamped source neighbours and
// the fractional weight between them. Purely combinational.
module dsa_coord_mapper
    import dsa_pkg::*;
#(
    parameter int FRAC_BITS   = DSA_FRAC_BITS,
    parameter int LANE_OFFSET = 0
) (
    input  logic [15:0]          coord,
    input  logic [15:0]          scale,
    input  logic [15:0]          size,
    output logic [15:0]          c0,
    output logic [15:0]          c1,
    output logic [FRAC_BITS-1:0] frac
);

    logic [31:0] pos;
    logic [31:0] prod;
    logic [16:0] lim;
    logic [16:0] a0;
    logic [16:0] a1;
    logic        unused_prod_hi;

    // Scaled position; the integer part is clamped to the last valid index.
    always_comb begin
        pos  = 32'(coord) + 32'(LANE_OFFSET);
        prod = pos * 32'(scale);
        lim  = {1'b0, size} - 17'd1;
        a0   = {1'b0, prod[FRAC_BITS+15:FRAC_BITS]};
        a1   = a0 + 17'd1;
        c0   = (a0 > lim) ? lim[15:0] : a0[15:0];
        c1   = (a1 > lim) ? lim[15:0] : a1[15:0];
        frac = prod[FRAC_BITS-1:0];
    end

    assign unused_prod_hi = ^prod[31:FRAC_BITS+16];

endmodule

// File: rtl/dsa_fetch_unit_simd.sv
// Fetches the four bilinear neighbours for each lane of a SIMD group from a
// byte-wide source memory with one-cycle read latency.
//
// state | meaning
// IDLE  | waiting for fetch_req
// CALC  | latch coordinates, sizes and scales
// READ  | issue 4*SIMD_WIDTH reads, lane 0 first
// DRAIN | capture the final read, latch fractions
// DONE  | fetch_done pulse, results valid
module dsa_fetch_unit_simd
    import dsa_pkg::*;
#(
    parameter int SIMD_WIDTH = DSA_SIMD_WIDTH,
    parameter int ADDR_WIDTH = 18,
    parameter int FRAC_BITS  = DSA_FRAC_BITS
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            fetch_req,
    output logic                            fetch_done,
    output logic                            busy,
    input  logic [15:0]                     current_x,
    input  logic [15:0]                     current_y,
    input  logic [15:0]                     img_width_in,
    input  logic [15:0]                     img_height_in,
    input  logic [15:0]                     scale_x,
    input  logic [15:0]                     scale_y,
    output logic                            mem_rd_en,
    output logic [ADDR_WIDTH-1:0]           mem_addr,
    input  logic [7:0]                      mem_rdata,
    output logic [8*SIMD_WIDTH-1:0]         pix_p00,
    output logic [8*SIMD_WIDTH-1:0]         pix_p01,
    output logic [8*SIMD_WIDTH-1:0]         pix_p10,
    output logic [8*SIMD_WIDTH-1:0]         pix_p11,
    output logic [FRAC_BITS*SIMD_WIDTH-1:0] frac_x,
    output logic [FRAC_BITS*SIMD_WIDTH-1:0] frac_y
);

    localparam int NRD = 4 * SIMD_WIDTH;
    localparam int CW  = $clog2(NRD);
    localparam int LW  = (CW > 2) ? CW - 2 : 1;

    fetch_state_t state, state_nxt;

    logic [15:0]   cur_x_r, cur_y_r, width_r, height_r, scale_x_r, scale_y_r;
    logic [CW-1:0] idx;
    logic          pend;
    logic [CW-1:0] pend_idx;
    logic [LW-1:0] rd_lane;
    logic [LW-1:0] pend_lane;
    logic [15:0]   xa, ya;
    logic [31:0]   rd_addr;
    logic          unused_addr_hi;

    logic [15:0]          x0_l [SIMD_WIDTH];
    logic [15:0]          x1_l [SIMD_WIDTH];
    logic [15:0]          y0_l [SIMD_WIDTH];
    logic [15:0]          y1_l [SIMD_WIDTH];
    logic [FRAC_BITS-1:0] fx_l [SIMD_WIDTH];
    logic [FRAC_BITS-1:0] fy_l [SIMD_WIDTH];

    for (genvar g = 0; g < SIMD_WIDTH; g++) begin : g_lane
        dsa_coord_mapper #(.FRAC_BITS(FRAC_BITS), .LANE_OFFSET(g)) u_map_x (
            .coord (cur_x_r),
            .scale (scale_x_r),
            .size  (width_r),
            .c0    (x0_l[g]),
            .c1    (x1_l[g]),
            .frac  (fx_l[g])
        );
        dsa_coord_mapper #(.FRAC_BITS(FRAC_BITS), .LANE_OFFSET(0)) u_map_y (
            .coord (cur_y_r),
            .scale (scale_y_r),
            .size  (height_r),
            .c0    (y0_l[g]),
            .c1    (y1_l[g]),
            .frac  (fy_l[g])
        );
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state and control outputs.
    always_comb begin
        state_nxt  = state;
        busy       = 1'b0;
        mem_rd_en  = 1'b0;
        fetch_done = 1'b0;
        case (state)
            IDLE:  if (fetch_req) state_nxt = CALC;
            CALC:  begin
                busy      = 1'b1;
                state_nxt = READ;
            end
            READ:  begin
                busy      = 1'b1;
                mem_rd_en = 1'b1;
                if (idx == CW'(NRD - 1)) state_nxt = DRAIN;
            end
            DRAIN: begin
                busy      = 1'b1;
                state_nxt = DONE;
            end
            DONE:  begin
                busy       = 1'b1;
                fetch_done = 1'b1;
                state_nxt  = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Read address: idx[1:0] picks the neighbour, upper bits pick the lane.
    always_comb begin
        rd_lane   = LW'(idx >> 2);
        pend_lane = LW'(pend_idx >> 2);
        xa        = idx[0] ? x1_l[rd_lane] : x0_l[rd_lane];
        ya        = idx[1] ? y1_l[rd_lane] : y0_l[rd_lane];
        rd_addr   = 32'(ya) * 32'(width_r) + 32'(xa);
        mem_addr  = mem_rd_en ? rd_addr[ADDR_WIDTH-1:0] : '0;
    end

    assign unused_addr_hi = ^rd_addr[31:ADDR_WIDTH];

    // Snapshot the request parameters so inputs may move during the fetch.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur_x_r   <= '0;
            cur_y_r   <= '0;
            width_r   <= 16'd1;
            height_r  <= 16'd1;
            scale_x_r <= '0;
            scale_y_r <= '0;
        end else if (state == CALC) begin
            cur_x_r   <= current_x;
            cur_y_r   <= current_y;
            width_r   <= img_width_in;
            height_r  <= img_height_in;
            scale_x_r <= scale_x;
            scale_y_r <= scale_y;
        end
    end

    // Issue index, advancing once per read.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                idx <= '0;
        else if (state == READ) idx <= idx + CW'(1);
        else                    idx <= '0;
    end

    // Capture read data one cycle after issue; reset drops any read in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend     <= 1'b0;
            pend_idx <= '0;
            pix_p00  <= '0;
            pix_p01  <= '0;
            pix_p10  <= '0;
            pix_p11  <= '0;
        end else begin
            pend     <= mem_rd_en;
            pend_idx <= idx;
            if (pend) begin
                case (pend_idx[1:0])
                    2'd0: pix_p00[8*int'(pend_lane) +: 8] <= mem_rdata;
                    2'd1: pix_p01[8*int'(pend_lane) +: 8] <= mem_rdata;
                    2'd2: pix_p10[8*int'(pend_lane) +: 8] <= mem_rdata;
                    default: pix_p11[8*int'(pend_lane) +: 8] <= mem_rdata;
                endcase
            end
        end
    end

    // Fractions are published with the neighbours so both change together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frac_x <= '0;
            frac_y <= '0;
        end else if (state == DRAIN) begin
            for (int i = 0; i < SIMD_WIDTH; i++) begin
                frac_x[FRAC_BITS*i +: FRAC_BITS] <= fx_l[i];
                frac_y[FRAC_BITS*i +: FRAC_BITS] <= fy_l[i];
            end
        end
    end

endmodule
